// File: rtl/psi_stream_out.sv
// ----------------------------------------------------------------------------
// psi_stream_out
//
// Streams the non-zero members of a finished private-set-intersection result
// array, lowest index first, one element per output handshake. Zero entries
// mean "no member" and are dropped without costing any cycles: the next index
// is found by a priority encoder over the remaining non-zero mask.
//
// After the last element (or right after an all-zero array) a one-cycle
// done pulse reports how many elements were streamed for that array.
//
// Parameters
//   W  bit width of each array element
//   K  number of elements in the intersection array (even, >= 2)
//
// Ports
//   clk        clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_array holds a finished PSI result
//   in_ready   block accepts a new array this cycle (only while idle)
//   in_array   K elements of W bits, element i at bits [(i+1)*W-1 : i*W]
//   out_valid  out_data holds an intersection element
//   out_ready  consumer accepts out_data this cycle
//   out_data   current non-zero element (zero whenever out_valid is low)
//   out_last   current element is the final non-zero element of the array
//   done       one-cycle pulse, array fully streamed
//   count      elements streamed for the last array, valid while done is high
// ----------------------------------------------------------------------------
module psi_stream_out #(
    parameter int W  = 2,
    parameter int K  = 2,
    localparam int CW = $clog2(K + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W*K-1:0]  in_array,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic            done,
    output logic [CW-1:0]   count
);

    // Index into the captured array.
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [K-1:0][W-1:0]    arr_reg;     // captured array
    logic [K-1:0]           mask_reg;    // non-zero flag per captured element
    logic [IW-1:0]          idx_reg;     // index of the element being offered
    logic [IW-1:0]          idx_next;
    logic [CW-1:0]          count_reg;

    logic [K-1:0]           in_mask;     // non-zero flags of the incoming array
    logic [K-1:0]           above_mask;  // non-zero captured elements past idx_reg
    logic [IW-1:0]          first_idx;   // lowest non-zero index of incoming array
    logic [IW-1:0]          above_idx;   // lowest non-zero index past idx_reg
    logic                   is_last;     // nothing left after the current element

    logic                   accept;
    logic                   fire;

    // ------------------------------------------------------------------
    // Per-element flags
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_mask
            assign in_mask[gi]    = |in_array[gi*W +: W];
            assign above_mask[gi] = mask_reg[gi] && (IW'(gi) > idx_reg);
        end
    endgenerate

    assign is_last = ~|above_mask;

    // Priority encoders: scanning from the top down leaves the lowest set
    // index in the result, so zero runs of any length are skipped at once.
    always_comb begin
        first_idx = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (in_mask[i]) begin
                first_idx = IW'(i);
            end
        end
    end

    always_comb begin
        above_idx = idx_reg;
        for (int i = K - 1; i >= 0; i--) begin
            if (above_mask[i]) begin
                above_idx = IW'(i);
            end
        end
    end

    assign accept = (state_reg == S_IDLE) && in_valid;
    assign fire   = (state_reg == S_EMIT) && out_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    // An all-zero array has nothing to stream; report at once.
                    state_next = (|in_mask) ? S_EMIT : S_DONE;
                end
            end
            S_EMIT: begin
                if (out_ready && is_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_data  = arr_reg[idx_reg];
                out_last  = is_last;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign count = count_reg;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // The index only moves on a handshake, so out_data and out_last stay
    // stable while the consumer stalls. On the final handshake the index is
    // left alone; the state leaves EMIT and out_data drops to zero anyway.
    always_comb begin
        idx_next = idx_reg;
        if (accept) begin
            idx_next = first_idx;
        end else if (fire && !is_last) begin
            idx_next = above_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_reg   <= '0;
            mask_reg  <= '0;
            idx_reg   <= '0;
            count_reg <= '0;
        end else begin
            idx_reg <= idx_next;
            if (accept) begin
                arr_reg   <= in_array;
                mask_reg  <= in_mask;
                count_reg <= '0;
            end else if (fire) begin
                // At most K handshakes per array, so this cannot wrap.
                count_reg <= count_reg + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_psi_stream_out.sv
// ----------------------------------------------------------------------------
// tb_psi_stream_out
//
// Self-checking bench for psi_stream_out with W=4, K=4. The expected output
// of each array is a queue of its non-zero elements in index order; every
// cycle after acceptance must offer the queue head until the queue is empty,
// and the cycle after that must carry the done pulse with the element count.
// ----------------------------------------------------------------------------
module tb_psi_stream_out;

    localparam int W  = 4;
    localparam int K  = 4;
    localparam int CW = $clog2(K + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W*K-1:0]  in_array = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic            done;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    psi_stream_out #(.W(W), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_array  (in_array),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [W*K-1:0] pack4(input int e0, input int e1,
                                             input int e2, input int e3);
        logic [W*K-1:0] v;
        v = '0;
        v[0*W +: W] = W'(e0);
        v[1*W +: W] = W'(e1);
        v[2*W +: W] = W'(e2);
        v[3*W +: W] = W'(e3);
        return v;
    endfunction

    // Offer one array and follow it to its done pulse.
    // mode 0: out_ready always high; 1: random; 2: low for the first 3 cycles.
    // poke: hold in_valid high with a different array while streaming.
    task automatic run_array(input logic [W*K-1:0] arr, input int mode,
                             input bit poke, input string name);
        logic [W-1:0] q[$];
        logic [W-1:0] e;
        int exp_count;
        int stall;
        int wait_cyc;
        bit finished;
        for (int i = 0; i < K; i++) begin
            e = arr[i*W +: W];
            if (e != '0) q.push_back(e);
        end
        exp_count = q.size();

        @(negedge clk);
        wait_cyc = 0;
        while (in_ready !== 1'b1 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_wait: got %b expected 1", name, in_ready);
        end

        in_valid = 1'b1;
        in_array = arr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (poke) begin
            in_valid = 1'b1;
            in_array = pack4(6, 6, 6, 6);
        end

        stall = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (stall < 3) ? 1'b0 : 1'b1;
            endcase
            @(negedge clk);
            if (q.size() > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== q[0]) begin
                    errors++;
                    $display("FAIL %s data: got valid=%b data=%0d expected valid=1 data=%0d",
                             name, out_valid, out_data, q[0]);
                end
                checks++;
                if (out_last !== (q.size() == 1)) begin
                    errors++;
                    $display("FAIL %s last: got %b expected %b", name, out_last, q.size() == 1);
                end
                checks++;
                if (done !== 1'b0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s emit_flags: got done=%b in_ready=%b expected 0 0",
                             name, done, in_ready);
                end
                if (out_ready) void'(q.pop_front());
                else stall++;
                $display("%s: cycle %0d out=%0d last=%b ready=%b", name, cyc, out_data, out_last, out_ready);
                @(posedge clk);
                #1;
            end else begin
                checks++;
                if (done !== 1'b1 || count !== CW'(exp_count)) begin
                    errors++;
                    $display("FAIL %s done: got done=%b count=%0d expected done=1 count=%0d",
                             name, done, count, exp_count);
                end
                checks++;
                if (out_valid !== 1'b0 || out_data !== '0) begin
                    errors++;
                    $display("FAIL %s done_out: got valid=%b data=%0d expected 0 0",
                             name, out_valid, out_data);
                end
                $display("%s: done count=%0d", name, count);
                finished = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done expected done within 64 cycles", name);
        end

        @(negedge clk);
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got done=%b in_ready=%b valid=%b expected 0 1 0",
                     name, done, in_ready, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            done !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL reset_hold: got valid=%b data=%0d last=%b done=%b count=%0d expected all 0",
                     out_valid, out_data, out_last, done, count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b valid=%b done=%b count=%0d expected 1 0 0 0",
                     in_ready, out_valid, done, count);
        end
        $display("test_reset: in_ready=%b", in_ready);
    endtask

    task automatic test_reset_mid_emit();
        @(negedge clk);
        in_valid = 1'b1;
        in_array = pack4(1, 2, 3, 4);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || done !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_immediate: got valid=%b data=%0d done=%b last=%b expected 0 0 0 0",
                     out_valid, out_data, done, out_last);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_after: got done=%b valid=%b in_ready=%b expected 0 0 1",
                         done, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
        $display("test_reset_mid_emit: recovered in_ready=%b", in_ready);
    endtask

    task automatic test_spec_vectors();
        run_array(pack4(0, 0, 5, 9), 0, 1'b0, "vec_sparse");
        run_array(pack4(0, 0, 0, 0), 1, 1'b0, "vec_empty");
        run_array(pack4(1, 2, 3, 4), 0, 1'b0, "vec_full");
        run_array(pack4(0, 7, 0, 3), 2, 1'b0, "vec_stall");
    endtask

    task automatic test_ignore_in_valid();
        run_array(pack4(5, 0, 0, 11), 1, 1'b1, "poke_during_emit");
        run_array(pack4(0, 0, 0, 0), 0, 1'b1, "poke_during_done");
    endtask

    task automatic test_random();
        logic [W*K-1:0] arr;
        for (int n = 0; n < 40; n++) begin
            arr = '0;
            for (int i = 0; i < K; i++) begin
                if ($urandom_range(0, 1) == 1) arr[i*W +: W] = W'($urandom_range(1, 15));
            end
            run_array(arr, ($urandom_range(0, 3) == 0) ? 0 : 1, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_ignore_in_valid();
        test_random();
        test_reset_mid_emit();
        run_array(pack4(8, 0, 13, 0), 0, 1'b0, "after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psi_stream_out.md
PSI_STREAM_OUT -- requirements
Module: psi_stream_out

Interface
REQ-001 Parameter W, default 2, bit width of each array element.
REQ-002 Parameter K, default 2, number of elements in the intersection array (even, >=2).
REQ-003 Local CW = ceil(log2(K+1)), width of the element count.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_array holds a finished PSI result.
REQ-007 in_ready  output  1  block accepts a new array this cycle.
REQ-008 in_array  input  W*K  PSI result, element i at bits [(i+1)*W-1 : i*W], value 0 = "no member".
REQ-009 out_valid  output  1  out_data holds an intersection element.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  W  current non-zero element.
REQ-012 out_last  output  1  current element is the final non-zero element of the array.
REQ-013 done  output  1  one-cycle pulse, array fully streamed.
REQ-014 count  output  CW  number of elements streamed for the last array, valid while done=1.

Function
REQ-015 The block SHALL stream the non-zero elements of each accepted array, in ascending index order, one per out handshake, and drop all zero elements.
REQ-016 FSM states: IDLE, EMIT, DONE.
REQ-017 IDLE: in_ready=1; on in_valid=1, register in_array and compute non-zero mask; go to EMIT if mask non-zero, else DONE.
REQ-018 Latency: accept in cycle t; first out_valid=1 (or done=1 if empty) in cycle t+1.
REQ-019 EMIT: out_valid=1; out_data = element at current index (registered); out_last=1 iff no non-zero element at a higher index.
REQ-020 Next index: priority encoder over the mask above the current index; zero runs skipped in zero cycles.
REQ-021 On out_valid&out_ready: count increments; if out_last, go to DONE; else load next non-zero element same edge (back-to-back throughput, one element/cycle).
REQ-022 While out_valid=1 and out_ready=0: out_data, out_last, and the index SHALL hold stable.
REQ-023 DONE: done=1 for exactly one cycle with count final; next cycle IDLE.
REQ-024 in_ready=0 in EMIT and DONE; in_valid in those states is ignored, with no capture.
REQ-025 out_ready while out_valid=0 is ignored.
REQ-026 count saturation impossible: count <= K by construction; count cleared on each accept.
REQ-027 out_data=0 whenever out_valid=0.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, out_data=0, out_last=0, done=0, count=0, and captured array and index cleared.
REQ-029 Reset mid-EMIT SHALL abandon the current array; no done pulse is issued for it.

Verification (W=4, K=4, elements listed idx0..idx3)
REQ-030 in {0,0,5,9}, out_ready=1, accept at t -> t+1 out 5 last=0; t+2 out 9 last=1; t+3 done=1 count=2; t+4 in_ready=1.
REQ-031 in {0,0,0,0} -> t+1 done=1 count=0; out_valid never 1.
REQ-032 in {1,2,3,4}, out_ready=1 -> out 1,2,3,4 on t+1..t+4, last only on 4; t+5 done=1 count=4.
REQ-033 in {0,7,0,3}, out_ready=0 for 3 cycles at first element -> out_data=7, out_valid=1 held 3 cycles; then 7, 3(last), done count=2.
REQ-034 in_valid=1 with {6,6,6,6} during EMIT of previous array -> in_ready=0, no capture, current stream unchanged.
REQ-035 rst_n low during EMIT -> out_valid=0, out_data=0, done=0 immediately; after release in_ready=1, no done pulse for the aborted array.
